// File: rtl/pong_game_ctrl_if.sv
// Purpose: bundles the match controller's button/miss inputs and score/timer/stop outputs.
// Latency: none, wires only.
// Backpressure: none; every signal is a plain level sampled or driven each cycle.
interface pong_game_ctrl_if;
    logic       start;
    logic       miss1;
    logic       miss2;
    logic       stop;
    logic [3:0] sec1;
    logic [3:0] sec0;
    logic [3:0] score1;
    logic [3:0] score2;
    logic       game_over;
    logic [1:0] winner;

    // Controller side: consumes buttons and misses, drives the game outputs.
    modport slave (
        input  start, miss1, miss2,
        output stop, sec1, sec0, score1, score2, game_over, winner
    );

    // Environment side: drives buttons and misses, observes the game outputs.
    modport master (
        output start, miss1, miss2,
        input  stop, sec1, sec0, score1, score2, game_over, winner
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// Purpose: Pong match controller - serve pacing, BCD countdown, scores, end-of-game and winner.
// Latency: all outputs registered; start rise -> SERVE next cycle, miss -> stop/score next cycle.
// Backpressure: none; level misses score once because only the PLAY-state sample is used.
module pong_game_ctrl #(
    parameter int unsigned TICKS_PER_SEC = 25_000_000,
    parameter int unsigned SERVE_TICKS   = 50_000_000,
    parameter int unsigned GAME_SECONDS  = 60,
    parameter int unsigned WIN_SCORE     = 9
) (
    input  logic               clk,
    input  logic               rst,
    pong_game_ctrl_if.slave    bus
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int SW = (SERVE_TICKS > 1)   ? $clog2(SERVE_TICKS)   : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);
    localparam logic [SW-1:0] SERVE_MAX = SW'(SERVE_TICKS - 1);
    localparam logic [3:0]    SEC1_INIT = 4'(GAME_SECONDS / 10);
    localparam logic [3:0]    SEC0_INIT = 4'(GAME_SECONDS % 10);
    localparam logic [3:0]    WIN4      = 4'(WIN_SCORE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SERVE,
        S_PLAY,
        S_POINT,
        S_OVER
    } state_t;

    state_t        state_q,     state_d;
    logic          stop_q,      stop_d;
    logic [3:0]    sec1_q,      sec1_d;
    logic [3:0]    sec0_q,      sec0_d;
    logic [3:0]    score1_q,    score1_d;
    logic [3:0]    score2_q,    score2_d;
    logic          game_over_q, game_over_d;
    logic [1:0]    winner_q,    winner_d;
    logic [PW-1:0] presc_q,     presc_d;
    logic [SW-1:0] serve_cnt_q, serve_cnt_d;
    logic          start_q,     start_d;

    logic       start_rise;
    logic       sec_tick;
    logic       timer_zero;
    logic [3:0] dec_sec1;
    logic [3:0] dec_sec0;
    logic       dec_zero;
    logic [1:0] win_code;
    logic       do_reload;

    // One-second decrement of the BCD timer, clamped at 00, and the winner encoding.
    always_comb begin
        start_rise = bus.start & ~start_q;
        sec_tick   = (presc_q == PRESC_MAX);
        timer_zero = (sec1_q == 4'd0) && (sec0_q == 4'd0);
        dec_sec1   = sec1_q;
        dec_sec0   = sec0_q;
        if (!timer_zero) begin
            if (sec0_q == 4'd0) begin
                dec_sec0 = 4'd9;
                dec_sec1 = sec1_q - 4'd1;
            end else begin
                dec_sec0 = sec0_q - 4'd1;
            end
        end
        dec_zero = (dec_sec1 == 4'd0) && (dec_sec0 == 4'd0);
        if (score1_q > score2_q) begin
            win_code = 2'b01;
        end else if (score1_q < score2_q) begin
            win_code = 2'b10;
        end else begin
            win_code = 2'b11;
        end
    end

    // Next-state and next-register values for the match FSM.
    always_comb begin
        state_d     = state_q;
        sec1_d      = sec1_q;
        sec0_d      = sec0_q;
        score1_d    = score1_q;
        score2_d    = score2_q;
        winner_d    = winner_q;
        presc_d     = presc_q;
        serve_cnt_d = serve_cnt_q;
        start_d     = bus.start;
        do_reload   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_rise) begin
                    do_reload = 1'b1;
                end
            end
            S_SERVE: begin
                if (serve_cnt_q == SERVE_MAX) begin
                    state_d = S_PLAY;
                end else begin
                    serve_cnt_d = serve_cnt_q + SW'(1);
                end
            end
            S_PLAY: begin
                if (sec_tick) begin
                    presc_d = '0;
                    sec1_d  = dec_sec1;
                    sec0_d  = dec_sec0;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
                if (bus.miss1 || bus.miss2) begin
                    if (bus.miss2 && (score1_q != WIN4)) begin
                        score1_d = score1_q + 4'd1;
                    end
                    if (bus.miss1 && (score2_q != WIN4)) begin
                        score2_d = score2_q + 4'd1;
                    end
                    state_d = S_POINT;
                end else if (sec_tick && dec_zero) begin
                    winner_d = win_code;
                    state_d  = S_OVER;
                end
            end
            S_POINT: begin
                if ((score1_q == WIN4) || (score2_q == WIN4) || timer_zero) begin
                    winner_d = win_code;
                    state_d  = S_OVER;
                end else begin
                    serve_cnt_d = '0;
                    state_d     = S_SERVE;
                end
            end
            S_OVER: begin
                if (start_rise) begin
                    do_reload = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new match starts from a fresh timer, zero scores and an empty prescaler.
        if (do_reload) begin
            score1_d    = '0;
            score2_d    = '0;
            sec1_d      = SEC1_INIT;
            sec0_d      = SEC0_INIT;
            presc_d     = '0;
            serve_cnt_d = '0;
            winner_d    = 2'b00;
            state_d     = S_SERVE;
        end

        stop_d      = (state_d != S_PLAY);
        game_over_d = (state_d == S_OVER);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            stop_q      <= 1'b1;
            sec1_q      <= SEC1_INIT;
            sec0_q      <= SEC0_INIT;
            score1_q    <= '0;
            score2_q    <= '0;
            game_over_q <= 1'b0;
            winner_q    <= 2'b00;
            presc_q     <= '0;
            serve_cnt_q <= '0;
            start_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            stop_q      <= stop_d;
            sec1_q      <= sec1_d;
            sec0_q      <= sec0_d;
            score1_q    <= score1_d;
            score2_q    <= score2_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
            presc_q     <= presc_d;
            serve_cnt_q <= serve_cnt_d;
            start_q     <= start_d;
        end
    end

    assign bus.stop      = stop_q;
    assign bus.sec1      = sec1_q;
    assign bus.sec0      = sec0_q;
    assign bus.score1    = score1_q;
    assign bus.score2    = score2_q;
    assign bus.game_over = game_over_q;
    assign bus.winner    = winner_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Purpose: self-checking bench for pong_game_ctrl with small timing parameters.
// Latency: checks each registered output 1 ns after the clock edge that produced it.
// Backpressure: none; stimulus is applied every cycle.
module tb_pong_game_ctrl;

    logic clk;
    logic rst_n;

    pong_game_ctrl_if bus ();

    pong_game_ctrl #(
        .TICKS_PER_SEC (4),
        .SERVE_TICKS   (3),
        .GAME_SECONDS  (12),
        .WIN_SCORE     (3)
    ) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       m1;
        logic       m2;
        logic       stop;
        logic [3:0] s1;
        logic [3:0] s0;
        logic [3:0] c1;
        logic [3:0] c2;
        logic       go;
        logic [1:0] w;
    } vec_t;

    vec_t vec [0:21];
    vec_t sb_q [$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int s, input int m1, input int m2, input int stp,
                                input int s1, input int s0, input int c1, input int c2,
                                input int go, input int w);
        vec_t v;
        v.start = s[0];
        v.m1    = m1[0];
        v.m2    = m2[0];
        v.stop  = stp[0];
        v.s1    = s1[3:0];
        v.s0    = s0[3:0];
        v.c1    = c1[3:0];
        v.c2    = c2[3:0];
        v.go    = go[0];
        v.w     = w[1:0];
        return v;
    endfunction

    // Drive inputs now, then advance one clock and settle 1 ns past the edge.
    task automatic step(input logic s, input logic m1, input logic m2);
        bus.start = s;
        bus.miss1 = m1;
        bus.miss2 = m2;
        @(posedge clk);
        #1;
    endtask

    // Advance with idle inputs until the ball is released, bounded.
    task automatic wait_play(input string name);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (bus.stop == 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        chk(name, int'(found), 1);
    endtask

    task automatic chk_all(input string tag, input int stp, input int s1, input int s0,
                           input int c1, input int c2, input int go, input int w);
        chk({tag, ".stop"},      int'(bus.stop),      stp);
        chk({tag, ".sec1"},      int'(bus.sec1),      s1);
        chk({tag, ".sec0"},      int'(bus.sec0),      s0);
        chk({tag, ".score1"},    int'(bus.score1),    c1);
        chk({tag, ".score2"},    int'(bus.score2),    c2);
        chk({tag, ".game_over"}, int'(bus.game_over), go);
        chk({tag, ".winner"},    int'(bus.winner),    w);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        vec_t e;

        // Rows: start, miss1, miss2 | stop, sec1, sec0, score1, score2, game_over, winner
        vec[0]  = mk(0,0,0, 1,1,2,0,0,0,0);   // idle after reset
        vec[1]  = mk(1,0,0, 1,1,2,0,0,0,0);   // start rise -> SERVE
        vec[2]  = mk(0,0,0, 1,1,2,0,0,0,0);
        vec[3]  = mk(0,0,0, 1,1,2,0,0,0,0);
        vec[4]  = mk(0,0,0, 0,1,2,0,0,0,0);   // PLAY at N+4
        vec[5]  = mk(0,0,0, 0,1,2,0,0,0,0);
        vec[6]  = mk(0,0,0, 0,1,2,0,0,0,0);
        vec[7]  = mk(0,0,0, 0,1,2,0,0,0,0);
        vec[8]  = mk(0,0,0, 0,1,1,0,0,0,0);   // first second elapsed
        vec[9]  = mk(0,1,0, 1,1,1,0,1,0,0);   // miss1 -> POINT, score2=1
        vec[10] = mk(0,1,0, 1,1,1,0,1,0,0);   // miss still held, no double count
        vec[11] = mk(0,1,0, 1,1,1,0,1,0,0);   // held miss ignored in SERVE
        vec[12] = mk(0,0,0, 1,1,1,0,1,0,0);
        vec[13] = mk(0,0,0, 0,1,1,0,1,0,0);   // PLAY 4 cycles after POINT
        vec[14] = mk(0,0,0, 0,1,1,0,1,0,0);   // prescaler carried across serve
        vec[15] = mk(0,0,0, 0,1,1,0,1,0,0);
        vec[16] = mk(0,0,0, 0,1,0,0,1,0,0);
        vec[17] = mk(0,1,1, 1,1,0,1,2,0,0);   // both miss -> both score
        vec[18] = mk(0,0,0, 1,1,0,1,2,0,0);   // POINT -> SERVE
        vec[19] = mk(1,0,0, 1,1,0,1,2,0,0);   // start ignored in SERVE
        vec[20] = mk(0,0,0, 1,1,0,1,2,0,0);
        vec[21] = mk(0,0,0, 0,1,0,1,2,0,0);

        bus.start = 1'b0;
        bus.miss1 = 1'b0;
        bus.miss2 = 1'b0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        #2;
        chk_all("reset", 1, 1, 2, 0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk_all("post_reset", 1, 1, 2, 0, 0, 0, 0);

        // Table-driven opening: start, serve, single miss, double miss, serve pacing.
        for (int i = 0; i < 22; i++) begin
            sb_q.push_back(vec[i]);
            step(vec[i].start, vec[i].m1, vec[i].m2);
            e = sb_q.pop_front();
            chk($sformatf("row%0d.stop", i),      int'(bus.stop),      int'(e.stop));
            chk($sformatf("row%0d.sec1", i),      int'(bus.sec1),      int'(e.s1));
            chk($sformatf("row%0d.sec0", i),      int'(bus.sec0),      int'(e.s0));
            chk($sformatf("row%0d.score1", i),    int'(bus.score1),    int'(e.c1));
            chk($sformatf("row%0d.score2", i),    int'(bus.score2),    int'(e.c2));
            chk($sformatf("row%0d.game_over", i), int'(bus.game_over), int'(e.go));
            chk($sformatf("row%0d.winner", i),    int'(bus.winner),    int'(e.w));
        end

        // Mid-PLAY asynchronous reset takes effect without a clock edge.
        rst_n = 1'b0;
        #2;
        chk_all("mid_reset", 1, 1, 2, 0, 0, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Time-out with no misses: PLAY lasts 48 cycles, draw.
        step(1'b1, 1'b0, 1'b0);
        wait_play("timeout.wait_play");
        n = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
            if (bus.game_over) break;
        end
        chk("timeout.play_cycles", n, 48);
        chk_all("timeout", 1, 0, 0, 0, 0, 1, 3);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk_all("over_hold", 1, 0, 0, 0, 0, 1, 3);

        // Restart from OVER.
        step(1'b1, 1'b0, 1'b0);
        chk_all("restart", 1, 1, 2, 0, 0, 0, 0);

        // Win by score: three miss2 events, each on the first PLAY cycle.
        for (int k = 1; k <= 3; k++) begin
            wait_play($sformatf("win.wait_play%0d", k));
            step(1'b0, 1'b0, 1'b1);
            chk($sformatf("win.score1_%0d", k), int'(bus.score1), k);
            chk($sformatf("win.stop_%0d", k),   int'(bus.stop),   1);
        end
        step(1'b0, 1'b0, 1'b0);
        chk_all("win_over", 1, 1, 2, 3, 0, 1, 1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk_all("win_frozen", 1, 1, 2, 3, 0, 1, 1);

        // Miss on the final tick: timer reaches 00 together with POINT.
        step(1'b1, 1'b0, 1'b0);
        chk_all("restart2", 1, 1, 2, 0, 0, 0, 0);
        wait_play("final.wait_play");
        for (int i = 0; i < 47; i++) begin
            step(1'b0, 1'b0, 1'b0);
        end
        chk_all("final.pre", 0, 0, 1, 0, 0, 0, 0);
        step(1'b0, 1'b1, 1'b0);
        chk_all("final.point", 1, 0, 0, 0, 1, 0, 0);
        step(1'b0, 1'b0, 1'b0);
        chk_all("final.over", 1, 0, 0, 0, 1, 1, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
